// File: rtl/soundweb_pkg.sv
// Shared constants, FSM state encoding and byte classification for the Soundweb London TX scheduler.
package soundweb_pkg;

    localparam logic [7:0] STX        = 8'h02;
    localparam logic [7:0] ETX        = 8'h03;
    localparam logic [7:0] ACK        = 8'h06;
    localparam logic [7:0] NAK        = 8'h15;
    localparam logic [7:0] ESC        = 8'h1B;
    localparam logic [7:0] ESC_OFFSET = 8'h80;
    localparam int         BODY_LEN   = 13;

    typedef enum logic [3:0] {
        S_IDLE, S_GRANT, S_STX, S_BODY, S_ESC2,
        S_CHK, S_CHK_ESC2, S_ETX, S_WAIT_ACK, S_DONE
    } state_e;

    function automatic logic is_reserved_byte(input logic [7:0] b);
        return (b == STX) || (b == ETX) || (b == ACK) || (b == NAK) || (b == ESC);
    endfunction

    // States in which a byte is being offered to the UART.
    function automatic logic is_byte_state(input state_e s);
        return (s == S_STX) || (s == S_BODY) || (s == S_ESC2) ||
               (s == S_CHK) || (s == S_CHK_ESC2) || (s == S_ETX);
    endfunction

endpackage

// File: rtl/soundweb_rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr_i (wrapping), one-hot grant plus index.
module soundweb_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IW-1:0]      idx_o,
    output logic               any_o
);

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int j;
            j = int'(ptr_i) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!any_o && req_i[j]) begin
                any_o      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/soundweb_tx_scheduler.sv
// Arbitrates Soundweb London requests and streams framed, escaped packets one byte at a time.
// Define SOUNDWEB_ACK_EN to build the ACK/NAK wait with timeout and retry.
module soundweb_tx_scheduler
    import soundweb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ACK_TIMEOUT = 100000,
    parameter int MAX_RETRY   = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [8*NUM_REQ-1:0]   req_command,
    input  logic [48*NUM_REQ-1:0]  req_address,
    input  logic [16*NUM_REQ-1:0]  req_sv,
    input  logic [32*NUM_REQ-1:0]  req_data,
    output logic [7:0]             tx_byte,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   done_ok,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] done_id
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] LAST_IDX = 4'(BODY_LEN - 1);

    state_e                     state_q, state_d;
    logic [3:0]                 idx_q, idx_d;
    logic [IW-1:0]              ptr_q, ptr_d, win_q, win_d;
    logic [NUM_REQ-1:0]         grant_q, grant_d;
    logic [BODY_LEN-1:0][7:0]   body_q, body_d;
    logic [7:0]                 tx_byte_q, tx_byte_d;
    logic                       tx_valid_q, tx_valid_d;
    logic                       ok_q, ok_d;
    logic [7:0]                 chk, cur_byte;
    logic [NUM_REQ-1:0]         arb_grant;
    logic [IW-1:0]              arb_idx;
    logic                       arb_any, accept;

`ifdef SOUNDWEB_ACK_EN
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retry_q, retry_d;
`else
    logic unused_rx;
    assign unused_rx = ^{rx_byte, rx_valid} ^ (ACK_TIMEOUT > 0) ^ (MAX_RETRY > 0);
`endif

    soundweb_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    assign accept = tx_valid_q & tx_ready;

    always_comb begin
        chk = '0;
        for (int i = 0; i < BODY_LEN; i++) chk = chk ^ body_q[i];
    end

    // NOTE: every next-state signal takes its current value first, so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        grant_d = grant_q;
        body_d  = body_q;
        ok_d    = ok_q;
`ifdef SOUNDWEB_ACK_EN
        timer_d = timer_q;
        retry_d = retry_q;
`endif
        case (state_q)
            S_IDLE: if (arb_any) begin
                win_d   = arb_idx;
                grant_d = arb_grant;
                state_d = S_GRANT;
            end
            S_GRANT: begin
                body_d[0] = req_command[int'(win_q)*8 +: 8];
                for (int k = 0; k < 6; k++) body_d[1+k] = req_address[int'(win_q)*48 + k*8 +: 8];
                for (int k = 0; k < 2; k++) body_d[7+k] = req_sv[int'(win_q)*16 + k*8 +: 8];
                for (int k = 0; k < 4; k++) body_d[9+k] = req_data[int'(win_q)*32 + k*8 +: 8];
                ptr_d   = (int'(win_q) == NUM_REQ - 1) ? '0 : win_q + 1'b1;
                state_d = S_STX;
            end
            S_STX: if (accept) begin
                idx_d   = '0;
                state_d = S_BODY;
            end
            S_BODY: if (accept) begin
                if (is_reserved_byte(body_q[idx_q])) state_d = S_ESC2;
                else if (idx_q == LAST_IDX)          state_d = S_CHK;
                else                                 idx_d   = idx_q + 4'd1;
            end
            S_ESC2: if (accept) begin
                if (idx_q == LAST_IDX) state_d = S_CHK;
                else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_BODY;
                end
            end
            S_CHK:      if (accept) state_d = is_reserved_byte(chk) ? S_CHK_ESC2 : S_ETX;
            S_CHK_ESC2: if (accept) state_d = S_ETX;
            S_ETX: if (accept) begin
`ifdef SOUNDWEB_ACK_EN
                timer_d = '0;
                state_d = S_WAIT_ACK;
`else
                ok_d    = 1'b1;
                state_d = S_DONE;
`endif
            end
`ifdef SOUNDWEB_ACK_EN
            S_WAIT_ACK: begin
                if (rx_valid && rx_byte == ACK) begin
                    ok_d    = 1'b1;
                    state_d = S_DONE;
                end else if ((rx_valid && rx_byte == NAK) || timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_STX;
                    end else begin
                        ok_d    = 1'b0;
                        state_d = S_DONE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
`endif
            S_DONE: begin
`ifdef SOUNDWEB_ACK_EN
                retry_d = '0;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Output bytes are registered: compute what the next state will offer.
        cur_byte   = body_q[idx_d];
        tx_valid_d = is_byte_state(state_d);
        case (state_d)
            S_STX:      tx_byte_d = STX;
            S_BODY:     tx_byte_d = is_reserved_byte(cur_byte) ? ESC : cur_byte;
            S_ESC2:     tx_byte_d = cur_byte + ESC_OFFSET;
            S_CHK:      tx_byte_d = is_reserved_byte(chk) ? ESC : chk;
            S_CHK_ESC2: tx_byte_d = chk + ESC_OFFSET;
            S_ETX:      tx_byte_d = ETX;
            default:    tx_byte_d = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the body buffer is reset too, so no X ever reaches tx_byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            ptr_q      <= '0;
            win_q      <= '0;
            grant_q    <= '0;
            body_q     <= '0;
            tx_byte_q  <= '0;
            tx_valid_q <= 1'b0;
            ok_q       <= 1'b0;
`ifdef SOUNDWEB_ACK_EN
            timer_q    <= '0;
            retry_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            grant_q    <= grant_d;
            body_q     <= body_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
            ok_q       <= ok_d;
`ifdef SOUNDWEB_ACK_EN
            timer_q    <= timer_d;
            retry_q    <= retry_d;
`endif
        end
    end

    assign tx_byte   = tx_byte_q;
    assign tx_valid  = tx_valid_q;
    assign req_ready = (state_q == S_GRANT) ? grant_q : '0;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign done_ok   = done & ok_q;
    assign done_id   = win_q;

endmodule

// File: tb/tb_soundweb_tx_scheduler.sv
// Self-checking bench for soundweb_tx_scheduler: byte scoreboard, vector table and corner-case sequences.
module tb_soundweb_tx_scheduler;

    localparam int NUM_REQ     = 2;
    localparam int ACK_TIMEOUT = 40;
    localparam int MAX_RETRY   = 3;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [8*NUM_REQ-1:0]  req_command = '0;
    logic [48*NUM_REQ-1:0] req_address = '0;
    logic [16*NUM_REQ-1:0] req_sv = '0;
    logic [32*NUM_REQ-1:0] req_data = '0;
    logic [7:0]            tx_byte;
    logic                  tx_valid;
    logic                  tx_ready = 1'b1;
    logic [7:0]            rx_byte = '0;
    logic                  rx_valid = 1'b0;
    logic                  busy, done, done_ok;
    logic [0:0]            done_id;

    soundweb_tx_scheduler #(
        .NUM_REQ(NUM_REQ), .ACK_TIMEOUT(ACK_TIMEOUT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_command(req_command), .req_address(req_address),
        .req_sv(req_sv), .req_data(req_data),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_byte(rx_byte), .rx_valid(rx_valid),
        .busy(busy), .done(done), .done_ok(done_ok), .done_id(done_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          r;
        logic [7:0]  cmd;
        logic [47:0] addr;
        logic [15:0] sv;
        logic [31:0] data;
        int          exp_len;
    } vec_t;

    vec_t       vecs[4];
    logic [7:0] exp_q[$];
    logic [7:0] rx_plan[$];
    int         n_checks = 0;
    int         n_fail = 0;
    bit         bp_en = 1'b0;
    int         accepted = 0;
    int         etx_cnt = 0;
    int         done_cnt = 0;
    int         rx_delay = 0;
    logic [7:0] rx_pend = '0;
    bit         hold = 1'b0;
    logic [7:0] hold_byte = '0;
    time        last_etx_t = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor, UART ready driver and ACK/NAK responder.
    always @(negedge clk) begin
        tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        rx_valid = 1'b0;
        if (rx_delay > 0) begin
            rx_delay--;
            if (rx_delay == 0) begin
                rx_valid = 1'b1;
                rx_byte  = rx_pend;
            end
        end
        if (hold && reset_n) begin
            check("hold_valid", tx_valid, 1'b1);
            check("hold_byte", tx_byte, hold_byte);
        end
        hold = 1'b0;
        if (tx_valid && tx_ready) begin
            accepted++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL tx_extra: got byte %02h, expected no byte", tx_byte);
            end else begin
                check("tx_byte", tx_byte, exp_q.pop_front());
            end
            if (tx_byte == 8'h03) begin
                etx_cnt++;
                last_etx_t = $time;
                if (rx_plan.size() > 0) begin
                    rx_pend  = rx_plan.pop_front();
                    rx_delay = 3;
                end
            end
        end else if (tx_valid) begin
            hold      = 1'b1;
            hold_byte = tx_byte;
        end
        if (done) done_cnt++;
    end

    task automatic push_esc(input logic [7:0] b);
        if (b == 8'h02 || b == 8'h03 || b == 8'h06 || b == 8'h15 || b == 8'h1B) begin
            exp_q.push_back(8'h1B);
            exp_q.push_back(b ^ 8'h80);
        end else begin
            exp_q.push_back(b);
        end
    endtask

    task automatic push_model(input logic [7:0] cmd, input logic [47:0] addr,
                              input logic [15:0] sv, input logic [31:0] data);
        logic [7:0] body[13];
        logic [7:0] c;
        body[0] = cmd;
        for (int k = 0; k < 6; k++) body[1+k] = addr[8*k +: 8];
        for (int k = 0; k < 2; k++) body[7+k] = sv[8*k +: 8];
        for (int k = 0; k < 4; k++) body[9+k] = data[8*k +: 8];
        c = '0;
        exp_q.push_back(8'h02);
        for (int k = 0; k < 13; k++) begin
            push_esc(body[k]);
            c = c ^ body[k];
        end
        push_esc(c);
        exp_q.push_back(8'h03);
    endtask

    task automatic expect_ack();
`ifdef SOUNDWEB_ACK_EN
        rx_plan.push_back(8'h06);
`endif
    endtask

    task automatic set_fields(input int r, input logic [7:0] cmd, input logic [47:0] addr,
                              input logic [15:0] sv, input logic [31:0] data);
        req_command[r*8 +: 8]   = cmd;
        req_address[r*48 +: 48] = addr;
        req_sv[r*16 +: 16]      = sv;
        req_data[r*32 +: 32]    = data;
    endtask

    task automatic request(input int r);
        int n = 0;
        req_valid[r] = 1'b1;
        while (req_ready == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("grant_vec", req_ready, NUM_REQ'(1) << r);
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_done(input int exp_id, input logic exp_ok, input int budget, output time t_done);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        t_done = $time;
        check("done_seen", done, 1'b1);
        check("done_ok", done_ok, exp_ok);
        check("done_id", done_id, exp_id);
        check("stream_left", exp_q.size(), 0);
        @(negedge clk);
        check("done_pulse_len", done, 1'b0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic push_literal(input int which);
        logic [7:0] plan_s[17] = '{8'h02, 8'h88, 8'h1B, 8'h82, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h8B, 8'h03};
        if (which == 0) begin
            foreach (plan_s[i]) exp_q.push_back(plan_s[i]);
        end else begin
            exp_q.push_back(8'h02); exp_q.push_back(8'h1B); exp_q.push_back(8'h86);
            for (int i = 0; i < 12; i++) exp_q.push_back(8'h00);
            exp_q.push_back(8'h1B); exp_q.push_back(8'h86); exp_q.push_back(8'h03);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        time t_done;
        int  base;
        int  dc;
        int  ec;

        vecs[0] = '{0, 8'h88, 48'h0000_0000_0002, 16'h0000, 32'h0100_0000, 17};
        vecs[1] = '{1, 8'h06, 48'h0, 16'h0, 32'h0, 18};
        vecs[2] = '{0, 8'h1B, 48'h02_1B_15_06_03_02, 16'h0603, 32'h1B02_1B15, 30};
        vecs[3] = '{1, 8'h40, 48'h6655_4433_2211, 16'h8877, 32'hCCBB_AA99, 16};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_done_ok", done_ok, 1'b0);
        check("rst_done_id", done_id, 1'b0);
        check("rst_req_ready", req_ready, '0);
        reset_n = 1'b1;
        @(negedge clk);

        // Plain send, escaped checksum, then plain send under backpressure.
        for (int pass = 0; pass < 3; pass++) begin
            if (pass == 1) set_fields(0, 8'h06, 48'h0, 16'h0, 32'h0);
            else           set_fields(0, 8'h88, 48'h02, 16'h0, 32'h0100_0000);
            bp_en = (pass == 2);
            push_literal(pass == 1 ? 1 : 0);
            expect_ack();
            base = accepted;
            request(0);
            check("busy_in_packet", busy, 1'b1);
            wait_done(0, 1'b1, 1000, t_done);
            check("literal_len", accepted - base, (pass == 1) ? 18 : 17);
        end
        bp_en = 1'b0;

        // Vector table.
        for (int v = 0; v < 4; v++) begin
            set_fields(vecs[v].r, vecs[v].cmd, vecs[v].addr, vecs[v].sv, vecs[v].data);
            push_model(vecs[v].cmd, vecs[v].addr, vecs[v].sv, vecs[v].data);
            expect_ack();
            base = accepted;
            request(vecs[v].r);
            wait_done(vecs[v].r, 1'b1, 1000, t_done);
            check("vec_len", accepted - base, vecs[v].exp_len);
            check("idle_after_done", busy, 1'b0);
        end

        // Round-robin with both requesters held.
        do_reset();
        set_fields(0, 8'h41, 48'h0, 16'h0, 32'h0);
        set_fields(1, 8'h42, 48'h1, 16'h0, 32'h0);
        req_valid = '1;
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            while (req_ready == '0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("rr_grant", req_ready, NUM_REQ'(1) << (k % 2));
            push_model(8'h41 + 8'(k % 2), 48'(k % 2), 16'h0, 32'h0);
            expect_ack();
            if (k == 3) req_valid = '0;
            wait_done(k % 2, 1'b1, 1000, t_done);
        end

`ifdef SOUNDWEB_ACK_EN
        // Three NAKs, then silence: four transmissions and a timeout failure.
        set_fields(0, 8'h77, 48'h0, 16'h0, 32'h0);
        for (int k = 0; k < 4; k++) push_model(8'h77, 48'h0, 16'h0, 32'h0);
        rx_plan.push_back(8'h15);
        rx_plan.push_back(8'h15);
        rx_plan.push_back(8'h15);
        ec = etx_cnt;
        request(0);
        wait_done(0, 1'b0, 2000, t_done);
        check("nak_tx_count", etx_cnt - ec, 4);
        check("ack_timeout_cycles", (t_done - last_etx_t) / 10, ACK_TIMEOUT + 1);
`endif

        // Reset in the middle of the body.
        set_fields(0, 8'h40, 48'h6655_4433_2211, 16'h8877, 32'hCCBB_AA99);
        push_model(8'h40, 48'h6655_4433_2211, 16'h8877, 32'hCCBB_AA99);
        base = accepted;
        request(0);
        for (int n = 0; n < 100 && accepted < base + 4; n++) @(negedge clk);
        check("mid_reach_body", accepted - base >= 4, 1'b1);
        dc = done_cnt;
        reset_n = 1'b0;
        #1;
        check("mid_tx_valid", tx_valid, 1'b0);
        check("mid_tx_byte", tx_byte, 8'h00);
        check("mid_busy", busy, 1'b0);
        check("mid_req_ready", req_ready, '0);
        exp_q.delete();
        rx_plan.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_no_done", done_cnt, dc);
        set_fields(0, 8'h88, 48'h02, 16'h0, 32'h0100_0000);
        push_literal(0);
        expect_ack();
        base = accepted;
        request(0);
        wait_done(0, 1'b1, 1000, t_done);
        check("post_reset_len", accepted - base, 17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/soundweb_tx_scheduler.md
Name: soundweb_tx_scheduler

Overview:
Arbitrates Soundweb London message requests from NUM_REQ local requesters and serialises the winner onto a byte-wide UART transmit interface. It frames each packet as STX, the escaped body, the escaped checksum, then ETX, and optionally waits for the device ACK/NAK with retry. It sits between the control sources and the UART transmitter. It replaces the combinational 29-byte packet build with a byte-at-a-time sequenced datapath.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
ACK_TIMEOUT, 100000, clk cycles to wait for ACK/NAK after ETX is accepted
MAX_RETRY, 3, retransmissions after NAK or timeout before failing

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  request pending, one bit per requester; held until granted
req_ready  out  NUM_REQ  one-cycle grant pulse; fields are latched that cycle
req_command  in  8*NUM_REQ  command byte per requester
req_address  in  48*NUM_REQ  address bytes; [7:0]=address_0 is sent first
req_sv  in  16*NUM_REQ  state variable bytes; [7:0]=sv_0 is sent first
req_data  in  32*NUM_REQ  data bytes; [7:0]=data_0 is sent first
tx_byte  out  8  byte to the UART
tx_valid  out  1  tx_byte is valid
tx_ready  in  1  UART accepts the byte when tx_valid && tx_ready
rx_byte  in  8  byte received from the UART
rx_valid  in  1  rx_byte is valid for one cycle
busy  out  1  a packet is in progress
done  out  1  one-cycle completion pulse
done_ok  out  1  qualifies done: 1=acknowledged/sent, 0=retries exhausted
done_id  out  $clog2(NUM_REQ) (min 1)  requester index of the completed packet

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE; round-robin pointer 0; retry count 0. Reset mid-packet aborts the packet with no done pulse.
- Reserved bytes are 0x02, 0x03, 0x06, 0x15 and 0x1B. A reserved byte is sent as 0x1B followed by (byte+0x80) mod 256.
- Body is 13 bytes in this order: command, address_0..5, sv_0..1, data_0..3. Every body byte may be escaped, including command.
- Checksum is the XOR of the 13 unescaped body bytes. It is escaped like a body byte. STX (0x02) and ETX (0x03) are never escaped.
- FSM states: IDLE, GRANT, STX, BODY, ESC2, CHK, CHK_ESC2, ETX, WAIT_ACK, DONE.
- IDLE: when any req_valid is set, pick the first set bit at or after the pointer (wrapping), then go to GRANT.
- GRANT: pulse req_ready for one cycle, latch the fields, set pointer = winner+1 mod NUM_REQ, then go to STX.
- Byte states drive tx_valid=1 and advance only on tx_valid && tx_ready. tx_byte/tx_valid are registered and stable while tx_ready=0.
- BODY: an escaped byte emits 0x1B, then ESC2 emits the offset byte, then BODY continues at the next index. After index 12, go to CHK.
- CHK and CHK_ESC2 behave the same way for the checksum, then go to ETX.
- ETX accepted: go to WAIT_ACK (see Optional Feature).
- WAIT_ACK: tx_valid=0. A timer counts from 0.
  - rx 0x06: done_ok=1, go to DONE.
  - rx 0x15 or timer == ACK_TIMEOUT-1: if retry count < MAX_RETRY, increment it and go to STX, resending the latched fields; otherwise done_ok=0 and go to DONE.
  - Other rx bytes are ignored. rx is also ignored in every other state.
- DONE: pulse done for one cycle, clear retry count, go to IDLE. The earliest next grant is the following cycle.
- busy=1 in every state except IDLE.
- A requester that drops req_valid before its grant is not served. A new req_valid during a packet waits for the next IDLE.
- Minimum unescaped packet is 16 bytes; maximum fully-escaped packet is 30 bytes.

Optional Feature:
- SOUNDWEB_ACK_EN defined: WAIT_ACK, the timeout and the retry logic are present as described.
- SOUNDWEB_ACK_EN undefined: ETX accepted goes directly to DONE with done_ok=1. rx_byte/rx_valid are unused, and the timer and retry counter are not built.

Decomposition:
- Package soundweb_pkg holds: STX=0x02, ETX=0x03, ACK=0x06, NAK=0x15, ESC=0x1B, ESC_OFFSET=0x80, BODY_LEN=13, the FSM state enum, and an is_reserved_byte function.
- One sub-module, soundweb_rr_arbiter: NUM_REQ-wide round-robin, with a request vector and pointer in and a one-hot grant plus index out.

Test Plan:
- Plain send: requester 0 sends cmd 0x88, address_0=0x02, all else 0 except data_3=0x01, with tx_ready tied 1 and ACK returned. Stream must be 02 88 1B 82 00 00 00 00 00 00 00 00 00 00 01 8B 03, then done=1, done_ok=1, done_id=0.
- Escaped checksum: cmd 0x06, all else 0. Stream must be 02 1B 86, then 12 bytes of 00, then 1B 86 03.
- Backpressure: toggle tx_ready randomly with 50% duty. The stream must be identical to the plain-send case, with tx_byte stable while tx_valid && !tx_ready.
- Round-robin: both req_valid held high. Grants must alternate 0,1,0,1 and done_id must match each grant.
- NAK/timeout (ACK_EN): reply 0x15 three times, then stay silent. Expect 4 transmissions, then done=1, done_ok=0 after ACK_TIMEOUT.
- Reset mid-packet: assert reset_n=0 during BODY. Outputs go 0 immediately, and no done pulse is seen; the next request must start with 0x02.
